// File: rtl/spi_pkg.sv
// Shared SPI definitions: slave state encoding, fill byte and CPHA mode constants
// common to the SPI master and slave.
package spi_pkg;

    localparam int unsigned SPI_BYTE_W = 8;
    localparam int unsigned SPI_CNT_W  = 3;

    localparam int unsigned SPI_CPHA0 = 0;
    localparam int unsigned SPI_CPHA1 = 1;

    localparam logic [SPI_BYTE_W-1:0] SPI_FILL_BYTE = 8'h00;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// N-flop input synchroniser with registered level and single-cycle rise/fall
// strobes derived from one extra registered copy of the synchronised level.
module spi_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_c_o,
    output logic fall_c_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o  = sync_q[STAGES-1];
    assign rise_c_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_c_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// 8-bit SPI slave (CPOL=0, selectable CPHA): oversamples sck/cs/mosi in the clk
// domain, delivers received bytes as rx_valid pulses and returns a preloaded reply.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned CPHA        = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_underrun,
    output logic       busy
);

    localparam bit SAMPLE_ON_FALL = (CPHA == SPI_CPHA1);

    logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_s;
    logic sck_lvl_unused, cs_lvl_unused, mosi_rise_unused, mosi_fall_unused;
    logic sample_c, drive_c;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk_i(clk), .rst_i(rst), .d_i(sck),
        .level_o(sck_lvl_unused), .rise_c_o(sck_rise), .fall_c_o(sck_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk_i(clk), .rst_i(rst), .d_i(cs),
        .level_o(cs_lvl_unused), .rise_c_o(cs_rise), .fall_c_o(cs_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk_i(clk), .rst_i(rst), .d_i(mosi),
        .level_o(mosi_s), .rise_c_o(mosi_rise_unused), .fall_c_o(mosi_fall_unused)
    );

    assign sample_c = SAMPLE_ON_FALL ? sck_fall : sck_rise;
    assign drive_c  = SAMPLE_ON_FALL ? sck_rise : sck_fall;

    spi_state_e           state_q, state_d;
    logic [7:0]           shift_q, shift_d, hold_q, hold_d, rx_shift_q, rx_shift_d;
    logic [7:0]           rx_data_q, rx_data_d, load_word, word;
    logic [SPI_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic hold_empty_q, hold_empty_d, done_q, done_d, reload_q, reload_d;
    logic pend_q, pend_d, miso_q, miso_d, underrun_q, underrun_d;
    logic rx_valid_q, rx_valid_d, busy_q, busy_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            hold_q       <= '0;
            rx_shift_q   <= '0;
            rx_data_q    <= '0;
            bit_cnt_q    <= '0;
            hold_empty_q <= 1'b1;
            done_q       <= 1'b0;
            reload_q     <= 1'b0;
            pend_q       <= 1'b0;
            miso_q       <= 1'b0;
            underrun_q   <= 1'b0;
            rx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            rx_shift_q   <= rx_shift_d;
            rx_data_q    <= rx_data_d;
            bit_cnt_q    <= bit_cnt_d;
            hold_empty_q <= hold_empty_d;
            done_q       <= done_d;
            reload_q     <= reload_d;
            pend_q       <= pend_d;
            miso_q       <= miso_d;
            underrun_q   <= underrun_d;
            rx_valid_q   <= rx_valid_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        rx_shift_d   = rx_shift_q;
        rx_data_d    = rx_data_q;
        bit_cnt_d    = bit_cnt_q;
        hold_empty_d = hold_empty_q;
        done_d       = 1'b0;
        reload_d     = reload_q;
        pend_d       = pend_q;
        miso_d       = miso_q;
        underrun_d   = 1'b0;
        rx_valid_d   = 1'b0;
        load_word    = hold_empty_q ? SPI_FILL_BYTE : hold_q;
        word         = reload_q ? load_word : shift_q;

        if (done_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d      = ST_ACTIVE;
                    shift_d      = load_word;
                    hold_empty_d = 1'b1;
                    underrun_d   = hold_empty_q;
                    bit_cnt_d    = '0;
                    reload_d     = 1'b0;
                    pend_d       = 1'b0;
                    miso_d       = SAMPLE_ON_FALL ? 1'b0 : load_word[7];
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_d    = ST_IDLE;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    reload_d   = 1'b0;
                    pend_d     = 1'b0;
                    miso_d     = 1'b0;
                end else begin
                    if (sample_c) begin
                        rx_shift_d = {rx_shift_q[6:0], mosi_s};
                        bit_cnt_d  = bit_cnt_q + SPI_CNT_W'(1);
                        underrun_d = pend_q;
                        pend_d     = 1'b0;
                        if (bit_cnt_q == SPI_CNT_W'(7)) begin
                            done_d   = 1'b1;
                            reload_d = 1'b1;
                        end
                    end
                    // A mid-burst fill byte only counts as underrun once its first bit is clocked out,
                    // so the trailing CPHA=0 reload before cs rises does not flag a spurious underrun.
                    if (drive_c) begin
                        if (reload_q) begin
                            hold_empty_d = 1'b1;
                            pend_d       = hold_empty_q;
                            reload_d     = 1'b0;
                        end
                        if (!SAMPLE_ON_FALL && reload_q) begin
                            shift_d = word;
                            miso_d  = word[7];
                        end else if (!SAMPLE_ON_FALL) begin
                            shift_d = {word[6:0], 1'b0};
                            miso_d  = word[6];
                        end else begin
                            shift_d = {word[6:0], 1'b0};
                            miso_d  = word[7];
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (tx_load && hold_empty_q) begin
            hold_d       = tx_data;
            hold_empty_d = 1'b0;
        end

        busy_d = (state_d == ST_ACTIVE);
    end

    assign miso        = miso_q;
    assign tx_ready    = hold_empty_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;
    assign busy        = busy_q;

endmodule
